snapshot_access_ctrl: RTL

SNAPSHOT_ACCESS_CTRL -- requirements
Module: snapshot_access_ctrl

---
 rtl/snapshot_access_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/snapshot_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : snapshot_access_ctrl
// Brief   : Sequences partitioned access to a wide snapshot register.
//           Reads run low->high, writes run high->low and commit on index 0.
// Revision: 1.0 - initial release
// ============================================================================
module snapshot_access_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int PARTITION_CNT = 2,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_vld,
    output logic                                req_rdy,
    input  logic                                req_wr,
    input  logic [3:0]                          req_idx,
    input  logic [DATA_WIDTH-1:0]               req_wdata,
    output logic                                rsp_vld,
    output logic                                rsp_err,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic [PARTITION_CNT-1:0]            snap_rd_en,
    output logic [PARTITION_CNT-1:0]            snap_wr_en,
    output logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_wr_data,
    input  logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_rd_data,
    output logic                                snap_soft_rst,
    output logic                                busy,
    output logic                                timeout_evt
);

    localparam logic [3:0]               c_LAST_IDX   = 4'(PARTITION_CNT - 1);
    localparam logic [4:0]               c_PART_CNT   = 5'(PARTITION_CNT);
    localparam logic [15:0]              c_TO_LAST    = 16'(TIMEOUT_CYC - 1);
    localparam logic [PARTITION_CNT-1:0] c_STROBE_LSB = PARTITION_CNT'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_SEQ = 2'd1,
        S_WR_SEQ = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [3:0]                   r_exp_idx;
    logic [3:0]                   w_exp_idx_nxt;
    logic [15:0]                  r_idle_cnt;

    logic                         r_rdy;
    logic                         r_rsp_vld;
    logic                         r_rsp_err;
    logic [PARTITION_CNT-1:0]     r_rd_en;
    logic [PARTITION_CNT-1:0]     r_wr_en;
    logic [DATA_WIDTH*PARTITION_CNT-1:0] r_wr_data;
    logic                         r_soft_rst;
    logic                         r_timeout;

    logic                         w_accept;
    logic                         w_oob;
    logic                         w_viol;
    logic                         w_err;
    logic                         w_timeout;
    logic [PARTITION_CNT-1:0]     w_rd_en_nxt;
    logic [PARTITION_CNT-1:0]     w_wr_en_nxt;
    logic [PARTITION_CNT-1:0]     w_strobe;
    logic [DATA_WIDTH-1:0]        w_rdata;

    assign w_accept = req_vld && r_rdy;
    assign w_oob    = ({1'b0, req_idx} >= c_PART_CNT);
    assign w_strobe = c_STROBE_LSB << req_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_exp_idx <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp_idx <= w_exp_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_exp_idx_nxt = r_exp_idx;
        w_rd_en_nxt   = '0;
        w_wr_en_nxt   = '0;
        w_viol        = 1'b0;
        w_err         = 1'b0;
        // An accept in the expiry cycle restarts the count, so it outranks the timeout.
        w_timeout     = (r_state != S_IDLE) && !w_accept && (r_idle_cnt == c_TO_LAST);

        if (w_accept) begin
            if (w_oob) begin
                w_err = 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!req_wr) begin
                            if (req_idx == 4'd0) begin
                                w_rd_en_nxt = w_strobe;
                                if (PARTITION_CNT > 1) begin
                                    w_state_nxt   = S_RD_SEQ;
                                    w_exp_idx_nxt = 4'd1;
                                end
                            end else begin
                                w_viol = 1'b1;
                            end
                        end else if (req_idx == 4'd0) begin
                            // Lone commit: upper partitions keep the current snapshot.
                            w_wr_en_nxt = w_strobe;
                        end else if (req_idx == c_LAST_IDX) begin
                            w_wr_en_nxt   = w_strobe;
                            w_state_nxt   = S_WR_SEQ;
                            w_exp_idx_nxt = req_idx - 4'd1;
                        end else begin
                            w_viol = 1'b1;
                        end
                    end
                    S_RD_SEQ: begin
                        if (!req_wr && (req_idx == r_exp_idx)) begin
                            w_rd_en_nxt = w_strobe;
                            if (req_idx == c_LAST_IDX) begin
                                w_state_nxt   = S_IDLE;
                                w_exp_idx_nxt = 4'd0;
                            end else begin
                                w_exp_idx_nxt = r_exp_idx + 4'd1;
                            end
                        end else begin
                            w_viol = 1'b1;
                        end
                    end
                    S_WR_SEQ: begin
                        if (req_wr && (req_idx == r_exp_idx)) begin
                            w_wr_en_nxt = w_strobe;
                            if (req_idx == 4'd0) begin
                                w_state_nxt   = S_IDLE;
                                w_exp_idx_nxt = 4'd0;
                            end else begin
                                w_exp_idx_nxt = r_exp_idx - 4'd1;
                            end
                        end else begin
                            w_viol = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt   = S_IDLE;
                        w_exp_idx_nxt = 4'd0;
                    end
                endcase
                if (w_viol) begin
                    w_err         = 1'b1;
                    w_rd_en_nxt   = '0;
                    w_wr_en_nxt   = '0;
                    w_state_nxt   = S_IDLE;
                    w_exp_idx_nxt = 4'd0;
                end
            end
        end else if (w_timeout) begin
            w_state_nxt   = S_IDLE;
            w_exp_idx_nxt = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy      <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rd_en    <= '0;
            r_wr_en    <= '0;
            r_wr_data  <= '0;
            r_soft_rst <= 1'b0;
            r_timeout  <= 1'b0;
            r_idle_cnt <= 16'd0;
        end else begin
            r_rsp_vld  <= w_accept;
            r_rsp_err  <= w_err;
            r_rd_en    <= w_rd_en_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_soft_rst <= w_viol || w_timeout;
            r_timeout  <= w_timeout;
            // Ready drops for any cycle carrying a response or a soft reset.
            r_rdy      <= !(w_accept || w_viol || w_timeout);
            if (w_accept) begin
                r_wr_data <= {PARTITION_CNT{req_wdata}};
            end
            if (w_accept) begin
                r_idle_cnt <= 16'd0;
            end else if (r_state != S_IDLE) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
        end
    end

    // Read data is sampled live in the response cycle; the strobe acts as slice select.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < PARTITION_CNT; i++) begin
            if (r_rd_en[i]) begin
                w_rdata = w_rdata | snap_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_rdy       = r_rdy;
    assign rsp_vld       = r_rsp_vld;
    assign rsp_err       = r_rsp_err;
    assign rsp_rdata     = w_rdata;
    assign snap_rd_en    = r_rd_en;
    assign snap_wr_en    = r_wr_en;
    assign snap_wr_data  = r_wr_data;
    assign snap_soft_rst = r_soft_rst;
    assign busy          = (r_state != S_IDLE);
    assign timeout_evt   = r_timeout;

endmodule
`default_nettype wire
